counter_rr_scheduler: RTL and testbench

Shares one CNT_W-bit up-counter between NUM_REQ requesters. Each requester asks for an interval of length N.
- Round-robin arbiter grants the counter to one requester at a time.
- Counter runs 0..N, then a one-cycle done pulse returns to the owner.
- Sits between control agents (timers, wait-state generators) and the shared counting datapath.

---
 rtl/counter_rr_scheduler.sv | 159 +++++++++++++++
 tb/tb_counter_rr_scheduler.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_rr_scheduler.sv
// Shares one CNT_W-bit up-counter between NUM_REQ requesters under round-robin arbitration.
// Define COUNTER_SCHED_FIXED_PRIO_EN for fixed priority (index 0 highest); the rr pointer is then removed.
module counter_rr_scheduler #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned CNT_W   = 4,
  localparam int unsigned ID_W   = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*CNT_W-1:0] req_len,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic                     abort,
  output logic [NUM_REQ-1:0]       done,
  output logic                     busy,
  output logic [ID_W-1:0]          owner,
  output logic [CNT_W-1:0]         count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COUNT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  len_q;
  logic [CNT_W-1:0]  len_sel;
  logic              grant_vld;
  logic [ID_W-1:0]   grant_idx;
  logic [NUM_REQ-1:0] owner_oh;

`ifdef COUNTER_SCHED_FIXED_PRIO_EN
  // Lowest requesting index wins; reverse scan so the lowest index is assigned last.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
      if (req_valid[ID_W'(i)]) begin
        grant_vld = 1'b1;
        grant_idx = ID_W'(i);
      end
    end
  end
`else
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] owner_inc;
  logic [ID_W:0]   scan_sum;
  logic [ID_W-1:0] scan_idx;

  assign owner_inc = (owner == ID_W'(NUM_REQ - 1)) ? '0 : owner + ID_W'(1);

  // Rotated scan from rr_ptr; one extra bit lets the wrap work for non-power-of-two NUM_REQ.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    scan_sum  = '0;
    scan_idx  = '0;
    for (int k = int'(NUM_REQ) - 1; k >= 0; k--) begin
      scan_sum = {1'b0, rr_ptr} + (ID_W+1)'(k);
      if (scan_sum >= (ID_W+1)'(NUM_REQ)) begin
        scan_sum = scan_sum - (ID_W+1)'(NUM_REQ);
      end
      scan_idx = scan_sum[ID_W-1:0];
      if (req_valid[scan_idx]) begin
        grant_vld = 1'b1;
        grant_idx = scan_idx;
      end
    end
  end

  // Pointer moves only when a job ends, so idle cycles never reshuffle priority.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if ((state == S_COUNT && abort) || state == S_DONE) begin
      rr_ptr <= owner_inc;
    end
  end
`endif

  always_comb begin
    len_sel = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (grant_idx == ID_W'(i)) begin
        len_sel = req_len[i*CNT_W +: CNT_W];
      end
    end
  end

  always_comb begin
    owner_oh        = '0;
    owner_oh[owner] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Abort takes priority over reaching the terminal count.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (grant_vld) state_nxt = S_COUNT;
      S_COUNT: begin
        if (abort) begin
          state_nxt = S_IDLE;
        end else if (count == len_q) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    if (state == S_IDLE && grant_vld) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
      owner <= '0;
      len_q <= '0;
      done  <= '0;
      busy  <= 1'b0;
    end else begin
      done <= (state == S_COUNT && state_nxt == S_DONE) ? owner_oh : '0;
      busy <= (state_nxt != S_IDLE);
      case (state)
        S_IDLE: begin
          if (grant_vld) begin
            len_q <= len_sel;
            owner <= grant_idx;
            count <= '0;
          end
        end
        S_COUNT: begin
          if (abort) begin
            count <= '0;
          end else if (count != len_q) begin
            count <= count + CNT_W'(1);
          end
        end
        default: count <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_counter_rr_scheduler.sv
// Bench for counter_rr_scheduler: directed steps plus random traffic against an elapsed-time job model.
module tb_counter_rr_scheduler;

  localparam int unsigned N  = 4;
  localparam int unsigned W  = 4;
  localparam int unsigned IW = 2;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_len;
  logic [N-1:0]   req_ready;
  logic           abort;
  logic [N-1:0]   done;
  logic           busy;
  logic [IW-1:0]  owner;
  logic [W-1:0]   count;

  counter_rr_scheduler #(.NUM_REQ(N), .CNT_W(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_len   (req_len),
    .req_ready (req_ready),
    .abort     (abort),
    .done      (done),
    .busy      (busy),
    .owner     (owner),
    .count     (count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  // Job model: a job is "active" for len+2 cycles after acceptance; t is cycles elapsed since accept.
  bit m_active;
  int m_t;
  int m_len;
  int m_owner;
  int m_ptr;
  int grants[$];

  function automatic int pick();
    int base;
`ifdef COUNTER_SCHED_FIXED_PRIO_EN
    base = 0;
`else
    base = m_ptr;
`endif
    for (int k = 0; k < int'(N); k++) begin
      if (req_valid[(base + k) % N]) return (base + k) % N;
    end
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs();
    int w;
    logic [N-1:0] er;
    logic [N-1:0] ed;
    int ec;
    bit eb;
    er = '0;
    ed = '0;
    ec = 0;
    eb = 1'b0;
    if (!m_active) begin
      w = pick();
      if (w >= 0) er[w] = 1'b1;
    end else if (m_t <= m_len) begin
      ec = m_t;
      eb = 1'b1;
    end else begin
      ec = m_len;
      eb = 1'b1;
      ed[m_owner] = 1'b1;
    end
    chk("req_ready", 32'(req_ready), 32'(er));
    chk("busy",      32'(busy),      32'(eb));
    chk("done",      32'(done),      32'(ed));
    chk("owner",     32'(owner),     32'(m_owner));
    chk("count",     32'(count),     32'(ec));
  endtask

  // One clock: check outputs, advance the model with the inputs present at the edge.
  task automatic cycle();
    int w;
    #1;
    check_outputs();
    if (!m_active) begin
      w = pick();
      if (w >= 0) begin
        m_active = 1'b1;
        m_t      = 0;
        m_len    = int'(req_len[w*W +: W]);
        m_owner  = w;
        grants.push_back(w);
      end
    end else if (m_t <= m_len) begin
      if (abort) begin
        m_active = 1'b0;
        m_ptr    = (m_owner + 1) % N;
      end else begin
        m_t++;
      end
    end else begin
      m_active = 1'b0;
      m_ptr    = (m_owner + 1) % N;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    m_active = 1'b0;
    m_owner  = 0;
    m_ptr    = 0;
    m_t      = 0;
    m_len    = 0;
    #1;
    check_outputs();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic set_len(input int idx, input int v);
    req_len[idx*W +: W] = W'(v);
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = '0;
    req_len   = '0;
    abort     = 1'b0;
    @(negedge clk);
    do_reset();

    // Single job, len 3: count 0..3 then done on requester 0
    req_valid = 4'b0001;
    set_len(0, 3);
    cycle();
    req_valid = '0;
    repeat (6) cycle();

    // All requesting, len 1: round-robin order from pointer 0
    do_reset();
    grants.delete();
    for (int i = 0; i < int'(N); i++) set_len(i, 1);
    req_valid = 4'b1111;
    repeat (17) cycle();
    req_valid = '0;
    repeat (4) cycle();
    chk("rr_grant_count", 32'(grants.size()), 32'd5);
    for (int i = 0; i < 5 && i < grants.size(); i++) chk("rr_order", 32'(grants[i]), 32'(i % 4));

    // Maximum length counts to all-ones without wrapping; then zero length
    req_valid = 4'b0010;
    set_len(1, 15);
    cycle();
    req_valid = '0;
    repeat (18) cycle();
    req_valid = 4'b0001;
    set_len(0, 0);
    cycle();
    req_valid = '0;
    repeat (3) cycle();

    // Abort at count 2 of len 5 for requester 2; next grant should go to requester 3
    do_reset();
    req_valid = 4'b0100;
    set_len(2, 5);
    cycle();
    req_valid = '0;
    cycle();
    cycle();
    abort = 1'b1;
    cycle();
    abort = 1'b0;
    req_valid = 4'b1001;
    set_len(3, 2);
    #1;
    chk("abort_next_ready", 32'(req_ready), 32'h8);
    chk("abort_no_done",    32'(done),      32'h0);
    chk("abort_count",      32'(count),     32'h0);
    cycle();
    req_valid = '0;
    repeat (6) cycle();

    // Abort on the same cycle the count reaches len: no done pulse
    req_valid = 4'b0001;
    set_len(0, 1);
    cycle();
    req_valid = '0;
    cycle();
    abort = 1'b1;
    cycle();
    abort = 1'b0;
    repeat (2) cycle();

    // Reset in the middle of a job
    req_valid = 4'b0010;
    set_len(1, 9);
    cycle();
    req_valid = '0;
    repeat (3) cycle();
    do_reset();
    repeat (2) cycle();

    // Requesters 1 and 3 held: fixed priority starves 3, round-robin alternates
    do_reset();
    grants.delete();
    set_len(1, 1);
    set_len(3, 1);
    req_valid = 4'b1010;
    repeat (13) cycle();
    req_valid = '0;
    repeat (4) cycle();
    chk("prio_grant_count", 32'(grants.size()), 32'd4);
    for (int i = 0; i < 4 && i < grants.size(); i++) begin
`ifdef COUNTER_SCHED_FIXED_PRIO_EN
      chk("prio_order", 32'(grants[i]), 32'd1);
`else
      chk("prio_order", 32'(grants[i]), (i % 2 == 0) ? 32'd1 : 32'd3);
`endif
    end

    // Random traffic with occasional aborts
    for (int c = 0; c < 600; c++) begin
      req_valid = N'($urandom);
      req_len   = (N*W)'($urandom);
      abort     = ($urandom_range(0, 9) == 0);
      cycle();
    end
    abort     = 1'b0;
    req_valid = '0;
    repeat (20) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
